freq_synth: RTL and testbench
=============================

# freq_synth

Programmable square-wave generator: the transmit-side counterpart of the frequency counter. It runs on the reference clock and produces a signal whose average frequency, in Hz, equals the requested value. It uses a Bresenham-style phase accumulator, so that frequency holds exactly over any whole number of seconds. Its output can be looped into the frequency counter for self-test of clock-monitoring paths, and it can drive a spare test-point or LED.

## Interface
- `CLOCK_FREQ`, default 32'd100_000_000: frequency of `ref_clk` in Hz. Must be even and ≥ 4.
- `ref_clk`  in  1: reference clock. It is the only clock in the block.
- `reset`  in  1: asynchronous, active-high reset. It clears every register.
- `enable`  in  1: level input. 1 = generate; 0 = stop glitch-free.
- `load`  in  1: single-cycle strobe. Samples `freq_in`.
- `freq_in`  in  32: requested frequency in Hz. Valid range 0 … CLOCK_FREQ/2.
- `f_out`  out  1: generated square wave. Registered, 50 % duty on average.
- `active`  out  1: 1 in RUN or STOPPING.
- `load_pending`  out  1: an accepted value is staged and not yet applied.
- `freq_cur`  out  32: frequency currently being generated.
- `load_err`  out  1: sticky. Set when a load is out of range.
- `edge_count`  out  32: number of rising edges of `f_out`. Wraps at 2^32.

## Operation
- **Reset values:** all outputs are 0, the state is IDLE, the accumulator `acc` is 0 and the staged register is 0.
- **States:** IDLE, RUN, STOPPING.
  - IDLE: `f_out` = 0 and `acc` is held at 0.
    - `enable` = 1 → RUN on the next edge.
  - RUN: the accumulator advances every cycle.
    - `enable` = 0 and `f_out` = 1 → STOPPING.
    - `enable` = 0 and `f_out` = 0 → IDLE, with `acc` cleared.
  - STOPPING: the accumulator keeps advancing.
    - The cycle that toggles `f_out` to 0 → IDLE, with `acc` cleared.
    - `enable` = 1 → RUN, with no phase disturbance.
- **Accumulator:** `acc` is 33 bits wide and always < CLOCK_FREQ. Each advancing cycle:
  - Compute sum = `acc` + 2·`freq_cur`.
  - If sum ≥ CLOCK_FREQ: `acc` ← sum − CLOCK_FREQ and `f_out` toggles.
  - Otherwise: `acc` ← sum.
  - Because 2·`freq_cur` ≤ CLOCK_FREQ, there is at most one toggle per cycle.
- **`freq_cur` = 0:** `acc` does not advance and `f_out` stays at its current level. In STOPPING, a zero `freq_cur` causes a forced toggle to 0 on the next cycle.
- **Load:**
  - `freq_in` > CLOCK_FREQ/2: the load is rejected. `load_err` ← 1 and nothing else changes.
  - Otherwise the value goes into the staged register and `load_pending` ← 1.
  - A later load while pending overwrites the staged value. Last one wins.
- **Apply of a staged value (`freq_cur` ← staged, `load_pending` ← 0):**
  - In IDLE, or when `freq_cur` = 0: applied on the cycle after the load.
  - In RUN or STOPPING: applied in the same cycle that `f_out` toggles 0→1, i.e. at a period boundary.
  - `acc` is kept at apply, so phase is continuous.
- **Load and apply in the same cycle:** the new load wins. It is staged, the old staged value is applied, and `load_pending` stays 1.
- **`edge_count`:** increments on each cycle where `f_out` goes 0→1. Only `reset` clears it.
- **Reset mid-operation:** immediate return to the reset values, including `f_out` = 0 asynchronously.

## Timing
- All outputs are registered on `ref_clk`. Only `reset` is asynchronous.
- **First rising edge:** for f = `freq_cur`, with IDLE→RUN on edge 0, `f_out` rises after k = ⌈CLOCK_FREQ/(2f)⌉ cycles.
  - Each half-period is ⌊CLOCK_FREQ/(2f)⌋ or ⌈CLOCK_FREQ/(2f)⌉ cycles.
  - Over CLOCK_FREQ cycles there are exactly f rising edges, ±1 at the window boundary.
- **f = CLOCK_FREQ/2:** `f_out` toggles every cycle.
- **`load_err`, `load_pending`:** update 1 cycle after the `load` strobe.
- **`active`:** follows the state register, so it is 1 cycle after `enable` changes.
- **Stop latency:** `f_out` never produces a high pulse shorter than its nominal half-period; the stop completes at the next falling toggle.

## Test plan
All scenarios use CLOCK_FREQ = 100.
1. **Basic generation:** reset; load 10; assert `enable` → `f_out` rises after 5 cycles, falls 5 cycles later, period 10 cycles; `edge_count` = 10 after 100 cycles.
2. **Non-integer ratio:** load 30 → half-periods alternate 1/2 cycles; exactly 30 rising edges in 100 cycles; `acc` stays < 100.
3. **Range limits:**
   - Load 50 → toggles every cycle.
   - Then load 51 → `load_err` = 1; `freq_cur` stays 50; `load_pending` stays 0.
4. **Boundary apply:** running at 10, load 25 mid-high phase → `load_pending` = 1 until the next 0→1 toggle; `freq_cur` = 25 in that same cycle; no half-period shorter than 2 cycles.
5. **Glitch-free stop:** running at 5, drop `enable` 3 cycles after a rising edge → `f_out` stays high for the full 10-cycle half-period, then falls; `active` goes 0; re-enable gives the first rise after 10 cycles.
6. **Async reset:** reset mid-high phase → `f_out`, `edge_count`, `freq_cur` and `load_err` go to 0 immediately; a loopback into the frequency counter reads 0.

Source files
------------

// File: rtl/freq_synth.sv
// Phase-accumulator square-wave generator: f_out averages exactly freq_cur Hz
// over CLOCK_FREQ reference cycles, with glitch-free stop and boundary-aligned reload.
module freq_synth #(
   parameter logic [31:0] CLOCK_FREQ = 32'd100_000_000
) (
   input  logic        ref_clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [31:0] freq_in,
   output logic        f_out,
   output logic        active,
   output logic        load_pending,
   output logic [31:0] freq_cur,
   output logic        load_err,
   output logic [31:0] edge_count
);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   localparam logic [32:0] CF33  = {1'b0, CLOCK_FREQ};
   localparam logic [31:0] F_MAX = CLOCK_FREQ >> 1;

   state_t      state_q, state_d;
   logic [32:0] acc_q, acc_d;
   logic        f_out_q, f_out_d;
   logic [31:0] staged_q, staged_d;
   logic        load_pending_q, load_pending_d;
   logic [31:0] freq_cur_q, freq_cur_d;
   logic        load_err_q, load_err_d;
   logic [31:0] edge_count_q, edge_count_d;

   logic [32:0] step_sum;
   logic [32:0] adv_acc;
   logic        step_en;
   logic        wrap;
   logic        rise;
   logic        apply;

   always_comb begin
      step_en  = (freq_cur_q != 32'd0);
      step_sum = acc_q + {freq_cur_q, 1'b0};
      wrap     = step_en && (step_sum >= CF33);
      if (wrap)         adv_acc = step_sum - CF33;
      else if (step_en) adv_acc = step_sum;
      else              adv_acc = acc_q;

      state_d        = state_q;
      acc_d          = acc_q;
      f_out_d        = f_out_q;
      staged_d       = staged_q;
      load_pending_d = load_pending_q;
      freq_cur_d     = freq_cur_q;
      load_err_d     = load_err_q;

      case (state_q)
         IDLE: begin
            acc_d   = 33'd0;
            f_out_d = 1'b0;
            if (enable) state_d = RUN;
         end
         default: begin
            acc_d   = adv_acc;
            f_out_d = f_out_q ^ wrap;
            if (enable) begin
               state_d = RUN;
            end else if (!f_out_q || wrap ||
                         (state_q == STOPPING && !step_en)) begin
               // Stop only on a low level or on the falling toggle itself.
               state_d = IDLE;
               acc_d   = 33'd0;
               f_out_d = 1'b0;
            end else begin
               state_d = STOPPING;
            end
         end
      endcase

      rise  = f_out_d & ~f_out_q;
      apply = load_pending_q && (state_q == IDLE || !step_en || rise);

      if (apply) begin
         freq_cur_d     = staged_q;
         load_pending_d = 1'b0;
      end
      // A load in the apply cycle re-stages and keeps pending set.
      if (load) begin
         if (freq_in > F_MAX) begin
            load_err_d = 1'b1;
         end else begin
            staged_d       = freq_in;
            load_pending_d = 1'b1;
         end
      end

      edge_count_d = edge_count_q + {31'd0, rise};
   end

   always_ff @(posedge ref_clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         acc_q          <= 33'd0;
         f_out_q        <= 1'b0;
         staged_q       <= 32'd0;
         load_pending_q <= 1'b0;
         freq_cur_q     <= 32'd0;
         load_err_q     <= 1'b0;
         edge_count_q   <= 32'd0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         f_out_q        <= f_out_d;
         staged_q       <= staged_d;
         load_pending_q <= load_pending_d;
         freq_cur_q     <= freq_cur_d;
         load_err_q     <= load_err_d;
         edge_count_q   <= edge_count_d;
      end
   end

   assign f_out        = f_out_q;
   assign active       = (state_q != IDLE);
   assign load_pending = load_pending_q;
   assign freq_cur     = freq_cur_q;
   assign load_err     = load_err_q;
   assign edge_count   = edge_count_q;

endmodule

// File: tb/tb_freq_synth.sv
// Directed bench for freq_synth at CLOCK_FREQ = 100 with hand-computed timings.
module tb_freq_synth;

   logic        ref_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        enable  = 1'b0;
   logic        load    = 1'b0;
   logic [31:0] freq_in = 32'd0;
   logic        f_out, active, load_pending, load_err;
   logic [31:0] freq_cur, edge_count;

   int checks = 0;
   int errors = 0;

   freq_synth #(.CLOCK_FREQ(32'd100)) dut (
      .ref_clk(ref_clk), .reset(reset), .enable(enable), .load(load),
      .freq_in(freq_in), .f_out(f_out), .active(active),
      .load_pending(load_pending), .freq_cur(freq_cur),
      .load_err(load_err), .edge_count(edge_count)
   );

   always #5 ref_clk = ~ref_clk;

   task automatic tick();
      @(posedge ref_clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0; load = 1'b0; freq_in = 32'd0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic do_load(input logic [31:0] v);
      load = 1'b1; freq_in = v;
      tick();
      load = 1'b0;
   endtask

   // Load and apply from IDLE, then enable; returns just after the IDLE->RUN edge.
   task automatic start(input logic [31:0] f);
      do_load(f);
      tick();
      enable = 1'b1;
      tick();
   endtask

   task automatic wait_level(input logic lvl, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (f_out !== lvl && n < 300);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (f_out !== 1'b0) begin errors++; $display("FAIL reset_f_out got %b want 0", f_out); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
      checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", load_pending); end
      checks++; if (freq_cur !== 32'd0) begin errors++; $display("FAIL reset_freq_cur got %0d want 0", freq_cur); end
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b want 0", load_err); end
      checks++; if (edge_count !== 32'd0) begin errors++; $display("FAIL reset_edge_count got %0d want 0", edge_count); end
   endtask

   task automatic test_basic();
      int n;
      do_reset();
      do_load(32'd10);
      checks++; if (load_pending !== 1'b1 || freq_cur !== 32'd0) begin errors++; $display("FAIL basic_staged got pend=%b cur=%0d want 1/0", load_pending, freq_cur); end
      tick();
      checks++; if (load_pending !== 1'b0 || freq_cur !== 32'd10) begin errors++; $display("FAIL basic_apply got pend=%b cur=%0d want 0/10", load_pending, freq_cur); end
      enable = 1'b1;
      tick();
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL basic_active got %b want 1", active); end
      wait_level(1'b1, n);
      checks++; if (n != 5) begin errors++; $display("FAIL basic_first_rise got %0d want 5", n); end
      wait_level(1'b0, n);
      checks++; if (n != 5) begin errors++; $display("FAIL basic_high got %0d want 5", n); end
      wait_level(1'b1, n);
      checks++; if (n != 5) begin errors++; $display("FAIL basic_low got %0d want 5", n); end
      repeat (100) tick();
      checks++; if (edge_count !== 32'd12) begin errors++; $display("FAIL basic_edge_count got %0d want 12", edge_count); end
   endtask

   task automatic test_nonint();
      int rises, run;
      logic prev;
      do_reset();
      start(32'd30);
      rises = 0; run = 0; prev = f_out;
      for (int i = 0; i < 100; i++) begin
         tick();
         run++;
         if (f_out !== prev) begin
            checks++; if (run < 1 || run > 2) begin errors++; $display("FAIL nonint_half_period got %0d want 1..2", run); end
            if (f_out) rises++;
            run = 0;
         end
         checks++; if (dut.acc_q >= 33'd100) begin errors++; $display("FAIL nonint_acc got %0d want <100", dut.acc_q); end
         prev = f_out;
      end
      checks++; if (rises != 30) begin errors++; $display("FAIL nonint_rises got %0d want 30", rises); end
      checks++; if (edge_count !== 32'd30) begin errors++; $display("FAIL nonint_edge_count got %0d want 30", edge_count); end
   endtask

   task automatic test_range();
      logic prev;
      do_reset();
      start(32'd50);
      prev = f_out;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (f_out === prev) begin errors++; $display("FAIL range_toggle got %b want %b", f_out, ~prev); end
         prev = f_out;
      end
      do_load(32'd51);
      checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL range_load_err got %b want 1", load_err); end
      checks++; if (freq_cur !== 32'd50) begin errors++; $display("FAIL range_freq_cur got %0d want 50", freq_cur); end
      checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL range_pending got %b want 0", load_pending); end
      checks++; if (f_out === prev) begin errors++; $display("FAIL range_toggle_after got %b want %b", f_out, ~prev); end
   endtask

   task automatic test_boundary();
      int n, run, minrun;
      logic prev;
      bit seen;
      do_reset();
      start(32'd10);
      wait_level(1'b1, n);
      tick(); tick();
      do_load(32'd25);
      checks++; if (load_pending !== 1'b1) begin errors++; $display("FAIL bound_pending got %b want 1", load_pending); end
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         prev = f_out;
         tick();
         if (f_out && !prev) begin
            seen = 1;
            checks++; if (freq_cur !== 32'd25 || load_pending !== 1'b0) begin errors++; $display("FAIL bound_apply got cur=%0d pend=%b want 25/0", freq_cur, load_pending); end
         end else begin
            checks++; if (freq_cur !== 32'd10 || load_pending !== 1'b1) begin errors++; $display("FAIL bound_hold got cur=%0d pend=%b want 10/1", freq_cur, load_pending); end
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL bound_timeout got none want rise"); end
      run = 0; minrun = 1000; prev = f_out;
      for (int i = 0; i < 20; i++) begin
         tick();
         run++;
         if (f_out !== prev) begin
            if (run < minrun) minrun = run;
            run = 0;
         end
         prev = f_out;
      end
      checks++; if (minrun != 2) begin errors++; $display("FAIL bound_min_half got %0d want 2", minrun); end
   endtask

   task automatic test_stop();
      int n, hi;
      do_reset();
      start(32'd5);
      wait_level(1'b1, n);
      checks++; if (n != 10) begin errors++; $display("FAIL stop_first_rise got %0d want 10", n); end
      tick(); tick(); tick();
      enable = 1'b0;
      hi = 3;
      tick(); hi++;
      checks++; if (active !== 1'b1 || f_out !== 1'b1) begin errors++; $display("FAIL stop_stopping got act=%b f=%b want 1/1", active, f_out); end
      while (f_out === 1'b1 && hi < 300) begin tick(); hi++; end
      checks++; if (hi != 10) begin errors++; $display("FAIL stop_high got %0d want 10", hi); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL stop_active got %b want 0", active); end
      enable = 1'b1;
      tick();
      wait_level(1'b1, n);
      checks++; if (n != 10) begin errors++; $display("FAIL stop_rerise got %0d want 10", n); end
   endtask

   task automatic test_zero();
      int n;
      do_reset();
      start(32'd10);
      wait_level(1'b1, n);
      do_load(32'd0);
      wait_level(1'b0, n);
      wait_level(1'b1, n);
      checks++; if (freq_cur !== 32'd0 || f_out !== 1'b1) begin errors++; $display("FAIL zero_apply got cur=%0d f=%b want 0/1", freq_cur, f_out); end
      repeat (3) tick();
      checks++; if (f_out !== 1'b1) begin errors++; $display("FAIL zero_hold got %b want 1", f_out); end
      enable = 1'b0;
      tick();
      checks++; if (f_out !== 1'b1 || active !== 1'b1) begin errors++; $display("FAIL zero_stopping got f=%b act=%b want 1/1", f_out, active); end
      tick();
      checks++; if (f_out !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL zero_forced got f=%b act=%b want 0/0", f_out, active); end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      start(32'd10);
      wait_level(1'b1, n);
      do_load(32'd20);
      repeat (8) tick();
      load = 1'b1; freq_in = 32'd40;
      tick();
      load = 1'b0;
      checks++; if (f_out !== 1'b1 || freq_cur !== 32'd20 || load_pending !== 1'b1) begin errors++; $display("FAIL b2b_apply got f=%b cur=%0d pend=%b want 1/20/1", f_out, freq_cur, load_pending); end
      wait_level(1'b0, n);
      checks++; if (n != 3) begin errors++; $display("FAIL b2b_high got %0d want 3", n); end
      wait_level(1'b1, n);
      checks++; if (n != 2) begin errors++; $display("FAIL b2b_low got %0d want 2", n); end
      checks++; if (freq_cur !== 32'd40 || load_pending !== 1'b0) begin errors++; $display("FAIL b2b_second got cur=%0d pend=%b want 40/0", freq_cur, load_pending); end
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      do_load(32'd99);
      start(32'd10);
      wait_level(1'b1, n);
      tick();
      #2;
      reset = 1'b1;
      #1;
      checks++; if (f_out !== 1'b0) begin errors++; $display("FAIL areset_f_out got %b want 0", f_out); end
      checks++; if (edge_count !== 32'd0 || freq_cur !== 32'd0 || load_err !== 1'b0) begin errors++; $display("FAIL areset_regs got ec=%0d cur=%0d err=%b want 0/0/0", edge_count, freq_cur, load_err); end
      tick(); tick();
      checks++; if (edge_count !== 32'd0 || f_out !== 1'b0) begin errors++; $display("FAIL areset_hold got ec=%0d f=%b want 0/0", edge_count, f_out); end
      reset = 1'b0;
      enable = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_nonint();
      test_range();
      test_boundary();
      test_stop();
      test_zero();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
